// File: rtl/multdiv_ctrl_pkg.sv
// multdiv_ctrl_pkg: shared state encodings, decode constants and default cycle counts for the mul/div sequencer.
package multdiv_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam int DEF_MUL_CYCLES = 32;
  localparam int DEF_DIV_CYCLES = 32;
  localparam int DEF_CNT_W      = 6;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_DIV   = 4'd11;
  // Decode raises start_mul for funct3[2]==0 and start_div otherwise.
  function automatic logic is_muldiv(input logic [6:0] opc, input logic [6:0] f7);
    return opc == OPC_OP && f7 == F7_MULDIV;
  endfunction
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction
endpackage

// File: rtl/multdiv_ctrl_counter.sv
// multdiv_ctrl_counter: iteration counter with sync clear, enable and terminal-count compare.
module multdiv_ctrl_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + CNT_W'(1);
  assign tc = count == last;
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the iterative mul/div datapath, stalls the pipeline and reports completion.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int DIV_CYCLES = DEF_DIV_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             divisor_zero,
  input  logic             flush,
  output logic             load_operands,
  output logic             step_en,
  output logic             mode,
  output logic [CNT_W-1:0] step_count,
  output logic             stall,
  output logic             busy,
  output logic             data_ready,
  output logic             data_exception
);
  state_t state, next;
  logic exc, tc, accept;
  logic [CNT_W-1:0] count, last;
  assign accept = state == IDLE && (start_mul || start_div) && !flush;
  assign last   = mode ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
  multdiv_ctrl_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (state != RUN || flush),
    .en   (state == RUN),
    .last (last),
    .count(count),
    .tc   (tc)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE: next = accept ? LOAD : IDLE;
      LOAD: next = flush ? IDLE : (mode && divisor_zero) ? DONE : RUN;
      RUN:  next = flush ? IDLE : tc ? DONE : RUN;
      DONE: next = IDLE;
    endcase
  end
  // The exception flag is only ever live in the DONE cycle that follows LOAD.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      mode  <= 1'b0;
      exc   <= 1'b0;
    end else begin
      state <= next;
      if (accept) mode <= !start_mul;
      exc <= state == LOAD && !flush && mode && divisor_zero;
    end
  assign load_operands  = state == LOAD;
  assign step_en        = state == RUN;
  assign step_count     = step_en ? count : '0;
  assign busy           = state != IDLE;
  assign data_ready     = state == DONE && !flush;
  assign data_exception = data_ready && exc;
  assign stall          = accept || load_operands || step_en;
endmodule
